// File: rtl/fullword_merge32.sv
// rtl/fullword_merge32.sv - round-robin 4-way dual-rail NCL word receiver with valid/ready output
module fullword_merge32 #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               init,
  input  logic [2*WIDTH-1:0] s_rail,
  input  logic [2*WIDTH-1:0] t_rail,
  input  logic [2*WIDTH-1:0] u_rail,
  input  logic [2*WIDTH-1:0] v_rail,
  output logic               s_comp,
  output logic               t_comp,
  output logic               u_comp,
  output logic               v_comp,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_port,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err_illegal,
  output logic [15:0]        word_count
);

  typedef enum logic {WAIT_DATA, WAIT_NULL} state_t;

  logic [2*WIDTH-1:0] rail_in [4];
  logic [2*WIDTH-1:0] sync_q  [4][SYNC_STAGES];
  logic [2*WIDTH-1:0] sel;
  logic [WIDTH-1:0]   word_true;
  logic               word_complete;
  logic               word_illegal;
  logic               word_null;
  logic               slot_free;
  state_t             state;
  logic [1:0]         ptr;
  logic [3:0]         comp;
  logic [15:0]        count;

  assign rail_in[0] = s_rail;
  assign rail_in[1] = t_rail;
  assign rail_in[2] = u_rail;
  assign rail_in[3] = v_rail;

  assign s_comp     = comp[0];
  assign t_comp     = comp[1];
  assign u_comp     = comp[2];
  assign v_comp     = comp[3];
  assign word_count = count;

  // Every rail crosses into the clock domain through its own flop chain.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      for (int p = 0; p < 4; p++)
        for (int k = 0; k < SYNC_STAGES; k++)
          sync_q[p][k] <= '0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        sync_q[p][0] <= rail_in[p];
        for (int k = 1; k < SYNC_STAGES; k++)
          sync_q[p][k] <= sync_q[p][k-1];
      end
    end
  end

  assign sel       = sync_q[ptr][SYNC_STAGES-1];
  assign word_null = (sel == '0);
  assign slot_free = !out_valid || out_ready;

  always_comb begin
    word_complete = 1'b1;
    word_illegal  = 1'b0;
    word_true     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      word_complete = word_complete & (sel[2*i] | sel[2*i+1]);
      word_illegal  = word_illegal  | (sel[2*i] & sel[2*i+1]);
      word_true[i]  = sel[2*i+1];
    end
  end

  // Rails only rise while waiting for DATA, so a single complete sample is final.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state       <= WAIT_DATA;
      ptr         <= 2'd0;
      comp        <= 4'b0000;
      out_data    <= '0;
      out_port    <= 2'd0;
      out_valid   <= 1'b0;
      err_illegal <= 1'b0;
      count       <= 16'd0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      case (state)
        WAIT_DATA: begin
          if (word_complete && slot_free) begin
            out_data    <= word_true;
            out_port    <= ptr;
            out_valid   <= 1'b1;
            comp        <= 4'b0001 << ptr;
            count       <= count + 16'd1;
            err_illegal <= err_illegal | word_illegal;
            state       <= WAIT_NULL;
          end
        end
        WAIT_NULL: begin
          if (word_null) begin
            comp  <= 4'b0000;
            ptr   <= ptr + 2'd1;
            state <= WAIT_DATA;
          end
        end
        default: state <= WAIT_DATA;
      endcase
    end
  end

endmodule
